mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the Mini MIPS core. It replaces the fixed 4-word array and free-running PC with a loadable synchronous instruction memory, a PC register that accepts branch and jump redirects, and a valid/ready output to decode. A 2-entry output buffer lets it sustain one instruction per cycle under decode back-pressure. It sits between the program loader/testbench and the control unit.

---
 rtl/mips_pkg.sv | 6 +
 rtl/mips_imem.sv | 20 ++
 rtl/mips_fetch_unit.sv | 90 +++++++++
 tb/tb_mips_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the Mini MIPS pipeline.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;
endpackage

// File: rtl/mips_imem.sv
// mips_imem: synchronous single-read single-write RAM; a same-address read/write returns old data.
module mips_imem #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC/redirect FSM issuing reads to mips_imem into a 2-entry in-order output buffer.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int PC_W = 32,
  parameter int RESET_PC = 0,
  parameter int AW = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_we,
  input  logic [AW-1:0]      imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [PC_W-1:0]    inst_pc,
  output logic [PC_W-1:0]    fetch_pc,
  output logic               fault
);
  logic [1:0] rst_sync;
  logic rst_n;
  fetch_state_t state;
  logic [1:0] count;
  logic pending;
  logic [PC_W-1:0] pend_pc;
  logic [INSTR_W-1:0] q_data [2];
  logic [PC_W-1:0] q_pc [2];
  logic [INSTR_W-1:0] rdata;
  logic pop, room, in_range, issue, widx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign pop = inst_valid && inst_ready;
  assign room = (count + {1'b0, pending} - {1'b0, pop}) < 2'd2;
  assign in_range = fetch_pc < PC_W'(IMEM_DEPTH);
  assign issue = state == RUN && !redirect_valid && room && in_range;
  // A push lands behind whatever survives this cycle's pop.
  assign widx = count[0] && !pop;
  assign inst_valid = count != 2'd0;
  assign inst_data = q_data[0];
  assign inst_pc = q_pc[0];
  assign fault = state == FAULT;
  mips_imem #(.DEPTH(IMEM_DEPTH), .WIDTH(INSTR_W)) u_imem (
    .clk  (clk),
    .we   (imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .re   (issue),
    .raddr(fetch_pc[AW-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= PC_W'(RESET_PC);
      count <= '0;
      pending <= 1'b0;
      pend_pc <= '0;
      q_data <= '{NOP, NOP};
      q_pc <= '{default: '0};
    end else if (redirect_valid) begin
      count <= '0;
      pending <= 1'b0;
      fetch_pc <= redirect_pc;
      state <= state == IDLE ? IDLE : (state == FAULT && redirect_pc >= PC_W'(IMEM_DEPTH)) ? FAULT : RUN;
    end else begin
      if (state == IDLE && start) state <= RUN;
      if (state == RUN && room && !in_range) state <= FAULT;
      pending <= issue;
      if (issue) begin
        pend_pc <= fetch_pc;
        fetch_pc <= fetch_pc + 1'b1;
      end
      count <= count + {1'b0, pending} - {1'b0, pop};
      if (pop) begin
        q_data[0] <= q_data[1];
        q_pc[0] <= q_pc[1];
      end
      if (pending) begin
        q_data[widx] <= rdata;
        q_pc[widx] <= pend_pc;
      end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed scenarios plus random redirect/back-pressure episodes checked against an in-order delivery model.
module tb_mips_fetch_unit;
  logic clk = 0;
  logic reset = 1;
  logic imem_we = 0;
  logic [1:0] imem_waddr = 0;
  logic [31:0] imem_wdata = 0;
  logic start = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic inst_ready = 0;
  logic inst_valid, fault;
  logic [31:0] inst_data, inst_pc, fetch_pc;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [4];
  logic [31:0] exp_pc = 0;
  int delivered = 0;
  logic stall_prev = 0;
  logic [31:0] prev_data, prev_pc, fp0;
  int t, r;

  mips_fetch_unit #(.IMEM_DEPTH(4), .PC_W(32), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start(start), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    imem_we = 1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we = 0;
    mem[a] = d;
  endtask

  // Model: held entries stay put; every transfer is the next word in program order since the last redirect.
  task automatic observe;
    if (stall_prev) begin
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_data", inst_data, prev_data);
      chk("hold_pc", inst_pc, prev_pc);
    end
    if (inst_valid && inst_ready) begin
      chk("xfer_pc", inst_pc, exp_pc);
      chk("xfer_data", inst_data, exp_pc < 4 ? mem[exp_pc[1:0]] : 32'hDEADBEEF);
      exp_pc++;
      delivered++;
    end
    stall_prev = inst_valid && !inst_ready && !redirect_valid;
    prev_data = inst_data;
    prev_pc = inst_pc;
  endtask

  task automatic step(input logic rdy);
    inst_ready = rdy;
    observe();
    tick();
  endtask

  task automatic redir(input logic [31:0] target, input logic rdy);
    redirect_valid = 1;
    redirect_pc = target;
    inst_ready = rdy;
    observe();
    exp_pc = target;
    delivered = 0;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    #1 reset = 0;
    tick();
    chk("rst_valid", {31'b0, inst_valid}, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    reset = 1;
    repeat (3) tick();
    wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44);
    repeat (10) step(0);
    chk("idle_valid", {31'b0, inst_valid}, 0);
    chk("idle_fetch_pc", fetch_pc, 0);
    chk("idle_fault", {31'b0, fault}, 0);
    redirect_valid = 1; redirect_pc = 2; tick(); redirect_valid = 0;
    repeat (2) tick();
    chk("idle_redir_pc", fetch_pc, 2);
    chk("idle_redir_valid", {31'b0, inst_valid}, 0);
    redirect_valid = 1; redirect_pc = 0; tick(); redirect_valid = 0;
    chk("idle_redir_back", fetch_pc, 0);
    // streaming from start
    start = 1; inst_ready = 1; tick(); start = 0;
    chk("start_lat0", {31'b0, inst_valid}, 0);
    tick();
    chk("start_lat1", {31'b0, inst_valid}, 0);
    tick();
    exp_pc = 0; delivered = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'b0, inst_valid}, 1);
      step(1);
    end
    chk("stream_fault", {31'b0, fault}, 1);
    repeat (3) step(1);
    chk("fault_no_more", {31'b0, inst_valid}, 0);
    chk("fault_hold", {31'b0, fault}, 1);
    chk("fault_fetch_pc", fetch_pc, 4);
    // back-pressure after first transfer
    redir(0, 1);
    chk("bp_fault_clear", {31'b0, fault}, 0);
    repeat (2) step(1);
    chk("bp_first_valid", {31'b0, inst_valid}, 1);
    fp0 = fetch_pc;
    step(1);
    for (int i = 0; i < 5; i++) begin
      inst_ready = 0;
      chk("bp_data", inst_data, 32'h22);
      chk("bp_pc", inst_pc, 1);
      chk("bp_fpc_bound", {31'b0, fetch_pc <= fp0 + 2}, 1);
      step(0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_release_valid", {31'b0, inst_valid}, 1);
      step(1);
    end
    chk("bp_count", delivered, 4);
    repeat (3) step(1);
    chk("bp_fault", {31'b0, fault}, 1);
    // redirect while PC 3 is in flight
    redir(0, 1);
    repeat (4) step(1);
    chk("rd_pre_pc", inst_pc, 2);
    redir(1, 1);
    chk("rd_flush0", {31'b0, inst_valid}, 0);
    step(1);
    chk("rd_flush1", {31'b0, inst_valid}, 0);
    step(1);
    chk("rd_target_valid", {31'b0, inst_valid}, 1);
    chk("rd_target_pc", inst_pc, 1);
    chk("rd_target_data", inst_data, 32'h22);
    repeat (3) step(1);
    repeat (3) step(1);
    chk("rd_count", delivered, 3);
    chk("rd_fault", {31'b0, fault}, 1);
    // asynchronous reset with the buffer full
    redir(0, 0);
    repeat (4) step(0);
    chk("ar_full_valid", {31'b0, inst_valid}, 1);
    chk("ar_full_pc", inst_pc, 0);
    #2 reset = 0;
    #1;
    chk("ar_valid", {31'b0, inst_valid}, 0);
    chk("ar_data", inst_data, 0);
    chk("ar_pc", inst_pc, 0);
    chk("ar_fetch_pc", fetch_pc, 0);
    chk("ar_fault", {31'b0, fault}, 0);
    stall_prev = 0;
    tick();
    reset = 1;
    repeat (3) tick();
    start = 1; inst_ready = 1; tick(); start = 0;
    exp_pc = 0; delivered = 0;
    repeat (2) step(1);
    chk("ar_replay_valid", {31'b0, inst_valid}, 1);
    repeat (6) step(1);
    chk("ar_replay_count", delivered, 4);
    chk("ar_replay_fault", {31'b0, fault}, 1);
    // random episodes of redirects and back-pressure
    for (int a = 0; a < 4; a++) wr(a[1:0], $urandom);
    for (int e = 0; e < 40; e++) begin
      t = $urandom_range(0, 5);
      redir(t, 1'($urandom % 2));
      r = $urandom_range(0, 8);
      repeat (r) step(1'($urandom % 4 != 0));
      if ($urandom % 2 == 1) begin
        t = $urandom_range(0, 5);
        redir(t, 1'($urandom % 2));
      end
      repeat (8) step(1);
      chk("ep_count", delivered, t < 4 ? 4 - t : 0);
      chk("ep_fault", {31'b0, fault}, 1);
      chk("ep_drained", {31'b0, inst_valid}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
